ddr_resp_model: RTL and testbench

Cycle-level DDR responder for the DDR port of `core_top`. It receives the single-word load/store and 512-bit instruction-burst requests that `channel_arb` issues on the `ddr_*` interface. It answers from an internal 64-bit-word memory array with a programmable latency. It sits in the simulation top beside `core_top` and is the only agent driving `ddr_ready`, `ddr_operation_done`, `ddr_opload_read_data` and `ddr_pc_read_inst`.

---
 rtl/ddr_resp_model_if.sv | 25 ++
 rtl/ddr_resp_model.sv | 142 ++++++++++++++
 tb/tb_ddr_resp_model.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ddr_resp_model_if.sv
// DDR request/response bundle between channel_arb (master) and the responder (slave).
interface ddr_resp_model_if;
  logic         ddr_chip_enable;
  logic [18:0]  ddr_index;
  logic         ddr_write_enable;
  logic         ddr_burst_mode;
  logic [63:0]  ddr_opstore_write_mask;
  logic [63:0]  ddr_opstore_write_data;
  logic [63:0]  ddr_opload_read_data;
  logic [511:0] ddr_pc_read_inst;
  logic         ddr_operation_done;
  logic         ddr_ready;

  modport master (
    output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
           ddr_opstore_write_mask, ddr_opstore_write_data,
    input  ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done, ddr_ready
  );

  modport slave (
    input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
           ddr_opstore_write_mask, ddr_opstore_write_data,
    output ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done, ddr_ready
  );
endinterface

// File: rtl/ddr_resp_model.sv
// Cycle-level DDR responder: one request in flight, programmable latency,
// single-word read/masked write and 8-beat wrapping instruction burst.
module ddr_resp_model #(
  parameter int LATENCY     = 4,
  parameter int BURST_BEATS = 8,
  parameter int DEPTH_LOG2  = 19
) (
  input  logic            clock,
  input  logic            reset,
  ddr_resp_model_if.slave bus
);
  localparam int AW = DEPTH_LOG2;
  localparam int BW = $clog2(BURST_BEATS);

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, DONE} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_BURST} op_t;

  logic [63:0] mem_q [2**AW];

  state_t                         state_q;
  op_t                            op_q;
  logic [AW-1:0]                  idx_q;
  logic [63:0]                    mask_q;
  logic [63:0]                    data_q;
  logic [7:0]                     cnt_q;
  logic [BW-1:0]                  beat_q;
  logic [BURST_BEATS-2:0][63:0]   stage_q;
  logic [63:0]                    rdata_q;
  logic [63:0]                    opload_q;
  logic [BURST_BEATS*64-1:0]      inst_q;
  logic                           ready_q;
  logic                           done_q;

  logic          accept;
  op_t           op_in;
  logic          rd_en;
  logic [AW-1:0] raddr;
  logic          wr_en;
  logic [63:0]   wr_word;

  assign accept = bus.ddr_chip_enable & ready_q;

  always_comb begin
    op_in = OP_READ;
    if (bus.ddr_burst_mode) op_in = OP_BURST;
    else if (bus.ddr_write_enable) op_in = OP_WRITE;
  end

  // Reads are issued one edge ahead of the state that consumes them; writes
  // also read first so the per-bit mask can be merged in DONE.
  always_comb begin
    rd_en = 1'b0;
    raddr = idx_q;
    case (state_q)
      IDLE: if (accept && LATENCY == 1) begin
        rd_en = 1'b1;
        raddr = bus.ddr_index[AW-1:0];
      end
      WAIT: if (cnt_q <= 8'd1) rd_en = 1'b1;
      BEAT: if (beat_q != BW'(BURST_BEATS - 1)) begin
        rd_en = 1'b1;
        raddr = idx_q + AW'(beat_q) + AW'(1);
      end
      default: ;
    endcase
  end

  assign wr_en   = (state_q == DONE) && (op_q == OP_WRITE) && !reset;
  assign wr_word = (rdata_q & ~mask_q) | (data_q & mask_q);

  always_ff @(posedge clock) begin
    if (rd_en) rdata_q <= mem_q[raddr];
    if (wr_en) mem_q[idx_q] <= wr_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      opload_q <= '0;
      inst_q   <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          idx_q   <= bus.ddr_index[AW-1:0];
          op_q    <= op_in;
          mask_q  <= bus.ddr_opstore_write_mask;
          data_q  <= bus.ddr_opstore_write_data;
          ready_q <= 1'b0;
          beat_q  <= '0;
          cnt_q   <= 8'(LATENCY - 1);
          if (LATENCY != 1) begin
            state_q <= WAIT;
          end else if (op_in == OP_BURST) begin
            state_q <= BEAT;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q > 8'd1) begin
            cnt_q <= cnt_q - 8'd1;
          end else if (op_q == OP_BURST) begin
            state_q <= BEAT;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        BEAT: begin
          if (beat_q == BW'(BURST_BEATS - 1)) begin
            inst_q  <= {rdata_q, stage_q};
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            for (int k = 0; k < BURST_BEATS - 1; k++) begin
              if (beat_q == BW'(k)) stage_q[k] <= rdata_q;
            end
            beat_q <= beat_q + BW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          if (op_q == OP_READ) opload_q <= rdata_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The RAM output register carries a fresh read word during DONE itself.
  assign bus.ddr_opload_read_data = (state_q == DONE && op_q == OP_READ) ? rdata_q : opload_q;
  assign bus.ddr_pc_read_inst     = inst_q;
  assign bus.ddr_operation_done   = done_q;
  assign bus.ddr_ready            = ready_q;
endmodule

// File: tb/tb_ddr_resp_model.sv
// Randomized and directed bench for ddr_resp_model at LATENCY 4 and 1,
// against a word-level memory model with cycle-exact completion times.
module tb_ddr_resp_model;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        ce = 1'b0, we = 1'b0, bm = 1'b0;
  logic [18:0] idx = '0;
  logic [63:0] mask = '0, wdat = '0;

  ddr_resp_model_if bus0();
  ddr_resp_model_if bus1();

  assign bus0.ddr_chip_enable        = ce & ~sel;
  assign bus0.ddr_index              = idx;
  assign bus0.ddr_write_enable       = we;
  assign bus0.ddr_burst_mode         = bm;
  assign bus0.ddr_opstore_write_mask = mask;
  assign bus0.ddr_opstore_write_data = wdat;
  assign bus1.ddr_chip_enable        = ce & sel;
  assign bus1.ddr_index              = idx;
  assign bus1.ddr_write_enable       = we;
  assign bus1.ddr_burst_mode         = bm;
  assign bus1.ddr_opstore_write_mask = mask;
  assign bus1.ddr_opstore_write_data = wdat;

  ddr_resp_model #(.LATENCY(4), .BURST_BEATS(8), .DEPTH_LOG2(19)) dut0 (
    .clock(clk), .reset(rst), .bus(bus0));
  ddr_resp_model #(.LATENCY(1), .BURST_BEATS(8), .DEPTH_LOG2(19)) dut1 (
    .clock(clk), .reset(rst), .bus(bus1));

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0]  ref_mem [int];
  logic [63:0]  ref_ld   [2];
  logic [511:0] ref_inst [2];
  logic [63:0]  last_ld;
  logic [511:0] last_inst;

  function automatic int key(bit s, logic [18:0] i);
    return int'({s, i});
  endfunction

  function automatic logic [63:0] peek(bit s, logic [18:0] i);
    return s ? dut1.mem_q[i] : dut0.mem_q[i];
  endfunction

  task automatic poke(bit s, logic [18:0] i, logic [63:0] v);
    ref_mem[key(s, i)] = v;
    if (s) dut1.mem_q[i] = v;
    else   dut0.mem_q[i] = v;
  endtask

  function automatic logic [1:0] rdy_done(bit s);
    return s ? {bus1.ddr_ready, bus1.ddr_operation_done}
             : {bus0.ddr_ready, bus0.ddr_operation_done};
  endfunction

  function automatic logic [63:0] ld_out(bit s);
    return s ? bus1.ddr_opload_read_data : bus0.ddr_opload_read_data;
  endfunction

  function automatic logic [511:0] inst_out(bit s);
    return s ? bus1.ddr_pc_read_inst : bus0.ddr_pc_read_inst;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic garbage(bit en);
    ce   = en ? 1'($urandom) : 1'b0;
    idx  = 19'($urandom);
    we   = 1'($urandom);
    bm   = 1'($urandom);
    mask = {$urandom, $urandom};
    wdat = {$urandom, $urandom};
  endtask

  // Issue one request at cycle T (the current negedge) and follow it to ready.
  task automatic do_op(bit s, bit w, bit b, logic [18:0] i, logic [63:0] m, logic [63:0] d);
    int lat, span;
    logic [63:0]  exp_ld;
    logic [511:0] exp_inst;
    lat  = s ? 1 : 4;
    span = b ? lat + 8 : lat;
    chk("ready_before_req", 512'(rdy_done(s)), 512'(2'b10));
    sel = s; ce = 1'b1; we = w; bm = b; idx = i; mask = m; wdat = d;
    exp_ld   = ref_ld[s];
    exp_inst = ref_inst[s];
    if (b) begin
      for (int k = 0; k < 8; k++) exp_inst[64*k +: 64] = ref_mem[key(s, i + 19'(k))];
    end else if (!w) begin
      exp_ld = ref_mem[key(s, i)];
    end
    for (int c = 1; c <= span + 1; c++) begin
      step();
      chk("ready_done_timing", 512'(rdy_done(s)), 512'({c == span + 1, c == span}));
      if (c >= span) begin
        chk(b ? "burst_hold_ld" : (w ? "write_hold_ld" : "read_data"), 512'(ld_out(s)), 512'(exp_ld));
        chk(b ? "burst_data" : "single_hold_inst", inst_out(s), exp_inst);
      end
      garbage(c <= span);
    end
    if (w && !b) ref_mem[key(s, i)] = (ref_mem[key(s, i)] & ~m) | (d & m);
    ref_ld[s]   = exp_ld;
    ref_inst[s] = exp_inst;
    last_ld     = ld_out(s);
    last_inst   = inst_out(s);
    $display("op lat=%0d %s idx=%05h done at T+%0d", lat, b ? "BURST" : (w ? "WRITE" : "READ "), i, span);
  endtask

  // Start a write (or burst) and pulse reset during the third cycle.
  task automatic rst_mid(bit s, bit b);
    logic [63:0] v;
    v = {$urandom, $urandom};
    poke(s, 19'h30, v);
    sel = s; ce = 1'b1; we = 1'b1; bm = b; idx = 19'h30; mask = '1; wdat = ~v;
    step();
    chk("rst_mid_no_done_t1", 512'(rdy_done(s)), 512'(2'b00));
    ce = 1'b0;
    step();
    chk("rst_mid_no_done_t2", 512'(rdy_done(s)), 512'(2'b00));
    rst = 1'b1;
    step();
    rst = 1'b0;
    ref_ld[0] = '0; ref_ld[1] = '0; ref_inst[0] = '0; ref_inst[1] = '0;
    for (int c = 0; c < 12; c++) begin
      chk("rst_mid_idle", 512'(rdy_done(s)), 512'(2'b10));
      step();
    end
    chk("rst_mid_mem", 512'(peek(s, 19'h30)), 512'(v));
    chk("rst_mid_inst", inst_out(s), 512'(0));
    $display("reset mid-op lat=%0d %s", s ? 1 : 4, b ? "BURST" : "WRITE");
  endtask

  initial begin
    logic [18:0] ri;
    bit rs, rw, rb;
    repeat (3) step();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk("reset_ready_done", 512'(rdy_done(1'(s))), 512'(2'b10));
      chk("reset_ld", 512'(ld_out(1'(s))), 512'(0));
      chk("reset_inst", inst_out(1'(s)), 512'(0));
      ref_ld[s] = '0;
      ref_inst[s] = '0;
      for (int i = 0; i < 32; i++) begin
        poke(1'(s), 19'(i), {$urandom, $urandom});
        poke(1'(s), 19'h7FFE0 + 19'(i), {$urandom, $urandom});
      end
    end
    $display("reset released, memories preloaded");

    poke(0, 19'h10, 64'hDEADBEEF_CAFEF00D);
    do_op(0, 0, 0, 19'h10, '0, '0);
    chk("read_after_reset", 512'(last_ld), 512'(64'hDEADBEEF_CAFEF00D));

    poke(0, 19'h20, 64'h1111_1111_1111_1111);
    do_op(0, 1, 0, 19'h20, 64'h0000_0000_FFFF_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(0, 0, 0, 19'h20, '0, '0);
    chk("masked_write", 512'(last_ld), 512'(64'h1111_1111_FFFF_1111));

    poke(0, 19'h7FFFE, 64'd1);
    poke(0, 19'h7FFFF, 64'd2);
    for (int k = 0; k < 6; k++) poke(0, 19'(k), 64'(k + 3));
    do_op(0, 0, 1, 19'h7FFFE, '0, '0);
    chk("burst_wrap", last_inst, {64'd8, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1});

    do_op(0, 1, 1, 19'h20, '1, 64'h0123_4567_89AB_CDEF);
    chk("burst_priority_mem", 512'(peek(0, 19'h20)), 512'(64'h1111_1111_FFFF_1111));
    chk("burst_priority_w0", 512'(last_inst[63:0]), 512'(64'h1111_1111_FFFF_1111));

    do_op(1, 0, 0, 19'h10, '0, '0);
    do_op(1, 1, 0, 19'h11, {$urandom, $urandom}, {$urandom, $urandom});
    do_op(1, 0, 0, 19'h11, '0, '0);
    do_op(1, 0, 1, 19'h7FFFC, '0, '0);

    for (int n = 0; n < 60; n++) begin
      rs = 1'($urandom);
      rb = ($urandom_range(0, 3) == 0);
      rw = 1'($urandom);
      ri = 1'($urandom) ? 19'($urandom_range(0, 24)) : 19'h7FFE0 + 19'($urandom_range(0, 31));
      do_op(rs, rw, rb, ri, {$urandom, $urandom}, {$urandom, $urandom});
    end

    rst_mid(0, 0);
    do_op(0, 0, 0, 19'h30, '0, '0);
    rst_mid(1, 1);
    do_op(1, 0, 0, 19'h30, '0, '0);

    foreach (ref_mem[k]) chk("mem_sweep", 512'(peek(k[19], k[18:0])), 512'(ref_mem[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
